// File: rtl/irig_b_encoder.sv
// IRIG-B (B00x) pulse-width timecode encoder with a loadable BCD time-of-year.
// Ports: clk, rst, enable, time_load + BCD time digits in; bcode_out, frame_start, bit_index, busy out.
module irig_b_encoder #(
  parameter int BIT_CYCLES = 500_000,
  parameter int P_HIGH     = 400_000,
  parameter int ONE_HIGH   = 250_000,
  parameter int ZERO_HIGH  = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       time_load,
  input  logic [3:0] second_units,
  input  logic [2:0] second_tens,
  input  logic [3:0] minute_units,
  input  logic [2:0] minute_tens,
  input  logic [3:0] hour_units,
  input  logic [1:0] hour_tens,
  input  logic [3:0] day_units,
  input  logic [3:0] day_tens,
  input  logic [1:0] day_hunds,
  input  logic [3:0] year_units,
  input  logic [3:0] year_tens,
  output logic       bcode_out,
  output logic       frame_start,
  output logic [6:0] bit_index,
  output logic       busy
);

  localparam int CW = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] P_W      = CW'(P_HIGH);
  localparam logic [CW-1:0] ONE_W    = CW'(ONE_HIGH);
  localparam logic [CW-1:0] ZERO_W   = CW'(ZERO_HIGH);

  typedef struct packed {
    logic [3:0] yr_t;
    logic [3:0] yr_u;
    logic [1:0] day_h;
    logic [3:0] day_t;
    logic [3:0] day_u;
    logic [1:0] hr_t;
    logic [3:0] hr_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } tod_t;

  typedef enum logic {
    IDLE,
    SYMBOL
  } state_t;

  // Leap year straight from the two BCD year digits.
  function automatic logic is_leap(
    logic [3:0] t,
    logic [3:0] u
  );
    if (t[0])
      return (u == 4'd2) || (u == 4'd6);
    return (u == 4'd0) || (u == 4'd4) ||
           (u == 4'd8);
  endfunction

  // One-second BCD ripple increment.
  function automatic tod_t tod_inc(tod_t t);
    tod_t r;
    logic c;
    logic lp;
    r  = t;
    c  = 1'b0;
    lp = is_leap(t.yr_t, t.yr_u);
    if (t.sec_u != 4'd9) begin
      r.sec_u = t.sec_u + 4'd1;
    end else begin
      r.sec_u = 4'd0;
      if (t.sec_t != 3'd5) begin
        r.sec_t = t.sec_t + 3'd1;
      end else begin
        r.sec_t = 3'd0;
        c = 1'b1;
      end
    end
    if (c) begin
      c = 1'b0;
      if (t.min_u != 4'd9) begin
        r.min_u = t.min_u + 4'd1;
      end else begin
        r.min_u = 4'd0;
        if (t.min_t != 3'd5) begin
          r.min_t = t.min_t + 3'd1;
        end else begin
          r.min_t = 3'd0;
          c = 1'b1;
        end
      end
    end
    if (c) begin
      c = 1'b0;
      if (t.hr_t == 2'd2 && t.hr_u == 4'd3) begin
        r.hr_t = 2'd0;
        r.hr_u = 4'd0;
        c = 1'b1;
      end else if (t.hr_u == 4'd9) begin
        r.hr_u = 4'd0;
        r.hr_t = t.hr_t + 2'd1;
      end else begin
        r.hr_u = t.hr_u + 4'd1;
      end
    end
    if (c) begin
      c = 1'b0;
      // Last day is 365, or 366 in a leap year; wraps to 001.
      if (t.day_h == 2'd3 && t.day_t == 4'd6 &&
          t.day_u == (lp ? 4'd6 : 4'd5)) begin
        r.day_h = 2'd0;
        r.day_t = 4'd0;
        r.day_u = 4'd1;
        c = 1'b1;
      end else if (t.day_u != 4'd9) begin
        r.day_u = t.day_u + 4'd1;
      end else begin
        r.day_u = 4'd0;
        if (t.day_t != 4'd9) begin
          r.day_t = t.day_t + 4'd1;
        end else begin
          r.day_t = 4'd0;
          r.day_h = t.day_h + 2'd1;
        end
      end
    end
    if (c) begin
      if (t.yr_u != 4'd9) begin
        r.yr_u = t.yr_u + 4'd1;
      end else begin
        r.yr_u = 4'd0;
        r.yr_t = (t.yr_t == 4'd9) ?
                 4'd0 : t.yr_t + 4'd1;
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    bit_index_q, bit_index_d;
  logic          busy_q, busy_d;
  logic          bcode_q, bcode_d;
  logic          frame_start_q, frame_start_d;
  tod_t          live_q, live_d;
  tod_t          shadow_q, shadow_d;
  tod_t          lbuf_q, lbuf_d;
  logic          pend_q, pend_d;

  tod_t          in_tod;
  logic          frame_end;
  logic          sym_p;
  logic          sym_one;
  logic [CW-1:0] sym_w;

  assign in_tod = {
    year_tens, year_units,
    day_hunds, day_tens, day_units,
    hour_tens, hour_units,
    minute_tens, minute_units,
    second_tens, second_units
  };

  // Symbol type for the current index, from the frame snapshot.
  always_comb begin
    sym_p   = 1'b0;
    sym_one = 1'b0;
    case (bit_index_q) inside
      7'd0, 7'd9, 7'd19, 7'd29, 7'd39,
      7'd49, 7'd59, 7'd69, 7'd79, 7'd89,
      7'd99:
        sym_p = 1'b1;
      [7'd1:7'd4]:
        sym_one = shadow_q.sec_u[2'(bit_index_q - 7'd1)];
      [7'd6:7'd8]:
        sym_one = shadow_q.sec_t[2'(bit_index_q - 7'd6)];
      [7'd10:7'd13]:
        sym_one = shadow_q.min_u[2'(bit_index_q - 7'd10)];
      [7'd15:7'd17]:
        sym_one = shadow_q.min_t[2'(bit_index_q - 7'd15)];
      [7'd20:7'd23]:
        sym_one = shadow_q.hr_u[2'(bit_index_q - 7'd20)];
      [7'd25:7'd26]:
        sym_one = shadow_q.hr_t[1'(bit_index_q - 7'd25)];
      [7'd30:7'd33]:
        sym_one = shadow_q.day_u[2'(bit_index_q - 7'd30)];
      [7'd35:7'd38]:
        sym_one = shadow_q.day_t[2'(bit_index_q - 7'd35)];
      [7'd40:7'd41]:
        sym_one = shadow_q.day_h[1'(bit_index_q - 7'd40)];
      [7'd50:7'd53]:
        sym_one = shadow_q.yr_u[2'(bit_index_q - 7'd50)];
      [7'd55:7'd58]:
        sym_one = shadow_q.yr_t[2'(bit_index_q - 7'd55)];
      default: ;
    endcase
    sym_w = sym_p ? P_W :
            (sym_one ? ONE_W : ZERO_W);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_index_d   = bit_index_q;
    busy_d        = busy_q;
    live_d        = live_q;
    shadow_d      = shadow_q;
    lbuf_d        = lbuf_q;
    pend_d        = pend_q;
    bcode_d       = 1'b0;
    frame_start_d = 1'b0;
    frame_end     = 1'b0;

    if (time_load) begin
      lbuf_d = in_tod;
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          frame_end   = 1'b1;
          state_d     = SYMBOL;
          cnt_d       = '0;
          bit_index_d = 7'd0;
          busy_d      = 1'b1;
        end
      end
      SYMBOL: begin
        bcode_d       = (cnt_q < sym_w);
        frame_start_d = (cnt_q == '0) &&
                        (bit_index_q == 7'd0);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_index_q == 7'd99) begin
            bit_index_d = 7'd0;
            frame_end   = 1'b1;
            if (!enable) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_index_d = bit_index_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // A strobe landing on the frame-end cycle itself wins directly.
    if (frame_end) begin
      if (time_load)
        live_d = in_tod;
      else if (pend_q)
        live_d = lbuf_q;
      else if (busy_q)
        live_d = tod_inc(live_q);
      pend_d = 1'b0;
      if (state_d == SYMBOL)
        shadow_d = live_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_index_q   <= 7'd0;
      busy_q        <= 1'b0;
      bcode_q       <= 1'b0;
      frame_start_q <= 1'b0;
      live_q        <= '0;
      shadow_q      <= '0;
      lbuf_q        <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_index_q   <= bit_index_d;
      busy_q        <= busy_d;
      bcode_q       <= bcode_d;
      frame_start_q <= frame_start_d;
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      lbuf_q        <= lbuf_d;
      pend_q        <= pend_d;
    end
  end

  assign bcode_out   = bcode_q;
  assign frame_start = frame_start_q;
  assign bit_index   = bit_index_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_irig_b_encoder.sv
// Self-checking bench for irig_b_encoder: captures whole frames and
// compares pulse widths and decoded time against an integer time model.
module tb_irig_b_encoder;

  localparam int BC = 50;
  localparam int PH = 40;
  localparam int OH = 25;
  localparam int ZH = 10;

  localparam int FS[11] = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
  localparam int FN[11] = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};

  typedef struct packed {
    int s;
    int m;
    int h;
    int d;
    int y;
  } tod_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       time_load = 1'b0;
  logic [3:0] second_units = '0;
  logic [2:0] second_tens = '0;
  logic [3:0] minute_units = '0;
  logic [2:0] minute_tens = '0;
  logic [3:0] hour_units = '0;
  logic [1:0] hour_tens = '0;
  logic [3:0] day_units = '0;
  logic [3:0] day_tens = '0;
  logic [1:0] day_hunds = '0;
  logic [3:0] year_units = '0;
  logic [3:0] year_tens = '0;
  logic       bcode_out;
  logic       frame_start;
  logic [6:0] bit_index;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  irig_b_encoder #(
    .BIT_CYCLES(BC),
    .P_HIGH    (PH),
    .ONE_HIGH  (OH),
    .ZERO_HIGH (ZH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .time_load   (time_load),
    .second_units(second_units),
    .second_tens (second_tens),
    .minute_units(minute_units),
    .minute_tens (minute_tens),
    .hour_units  (hour_units),
    .hour_tens   (hour_tens),
    .day_units   (day_units),
    .day_tens    (day_tens),
    .day_hunds   (day_hunds),
    .year_units  (year_units),
    .year_tens   (year_tens),
    .bcode_out   (bcode_out),
    .frame_start (frame_start),
    .bit_index   (bit_index),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic tod_t mk(int s, int m, int h, int d, int y);
    tod_t t;
    t.s = s;
    t.m = m;
    t.h = h;
    t.d = d;
    t.y = y;
    return t;
  endfunction

  // Reference clock: plain seconds/minutes/... arithmetic.
  function automatic tod_t tinc(tod_t t);
    tod_t r;
    int   dmax;
    r    = t;
    dmax = (r.y % 4 == 0) ? 366 : 365;
    r.s++;
    if (r.s == 60) begin r.s = 0; r.m++; end
    if (r.m == 60) begin r.m = 0; r.h++; end
    if (r.h == 24) begin r.h = 0; r.d++; end
    if (r.d > dmax) begin
      r.d = 1;
      r.y = (r.y + 1) % 100;
    end
    return r;
  endfunction

  function automatic int digit(tod_t t, int i);
    case (i)
      0:  return t.s % 10;
      1:  return t.s / 10;
      2:  return t.m % 10;
      3:  return t.m / 10;
      4:  return t.h % 10;
      5:  return t.h / 10;
      6:  return t.d % 10;
      7:  return (t.d / 10) % 10;
      8:  return t.d / 100;
      9:  return t.y % 10;
      default: return t.y / 10;
    endcase
  endfunction

  function automatic int exp_w(tod_t t, int k);
    if (k == 0 || k % 10 == 9)
      return PH;
    for (int i = 0; i < 11; i++)
      if (k >= FS[i] && k < FS[i] + FN[i])
        return ((digit(t, i) >> (k - FS[i])) & 1) != 0 ? OH : ZH;
    return ZH;
  endfunction

  task automatic drive_tod(input tod_t t);
    second_units = 4'(digit(t, 0));
    second_tens  = 3'(digit(t, 1));
    minute_units = 4'(digit(t, 2));
    minute_tens  = 3'(digit(t, 3));
    hour_units   = 4'(digit(t, 4));
    hour_tens    = 2'(digit(t, 5));
    day_units    = 4'(digit(t, 6));
    day_tens     = 4'(digit(t, 7));
    day_hunds    = 2'(digit(t, 8));
    year_units   = 4'(digit(t, 9));
    year_tens    = 4'(digit(t, 10));
  endtask

  task automatic wait_idx(input int k);
    int n;
    n = 0;
    while (int'(bit_index) != k && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_idx%0d", k), int'(bit_index), k);
  endtask

  // Capture one frame starting at the frame_start cycle and check it.
  task automatic grab_frame(input tod_t e, input string tag);
    int w[100];
    int dv[11];
    int n;
    int bidx_bad;
    int fs_extra;
    bit seen0;
    n = 0;
    while (frame_start !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fs"}, int'(frame_start), 1);
    bidx_bad = 0;
    fs_extra = 0;
    for (int k = 0; k < 100; k++) begin
      w[k]  = 0;
      seen0 = 1'b0;
      for (int j = 0; j < BC; j++) begin
        if (bcode_out === 1'b1) begin
          if (seen0 || w[k] < 0) w[k] = -1;
          else w[k]++;
        end else begin
          seen0 = 1'b1;
        end
        if (j == 25 && int'(bit_index) != k) bidx_bad++;
        if (!(k == 0 && j == 0) && frame_start !== 1'b0)
          fs_extra++;
        @(negedge clk);
      end
    end
    check({tag, "_bidx_steps"}, bidx_bad, 0);
    check({tag, "_fs_once"}, fs_extra, 0);
    for (int k = 0; k < 100; k++)
      check($sformatf("%s_sym%0d", tag, k), w[k], exp_w(e, k));
    for (int i = 0; i < 11; i++) begin
      dv[i] = 0;
      for (int b = 0; b < FN[i]; b++)
        if (w[FS[i] + b] == OH) dv[i] += (1 << b);
    end
    check({tag, "_sec"}, dv[1] * 10 + dv[0], e.s);
    check({tag, "_min"}, dv[3] * 10 + dv[2], e.m);
    check({tag, "_hour"}, dv[5] * 10 + dv[4], e.h);
    check({tag, "_day"}, dv[8] * 100 + dv[7] * 10 + dv[6], e.d);
    check({tag, "_year"}, dv[10] * 10 + dv[9], e.y);
  endtask

  initial begin
    tod_t cur;
    tod_t l0;
    tod_t b[5];
    int   n;
    int   ry;

    repeat (5) @(negedge clk);
    check("rst_bcode", int'(bcode_out), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_idx", int'(bit_index), 0);
    check("rst_busy", int'(busy), 0);

    // Frame of the reset time; enable dropped mid-frame.
    rst = 1'b0;
    fork
      grab_frame(mk(0, 0, 0, 0, 0), "f0");
      begin
        wait_idx(30);
        enable = 1'b0;
      end
    join
    check("idle_busy", int'(busy), 0);
    check("idle_bcode", int'(bcode_out), 0);
    n = 0;
    repeat (120) begin
      @(negedge clk);
      if (frame_start !== 1'b0 || busy !== 1'b0 || bcode_out !== 1'b0)
        n++;
    end
    check("idle_quiet", n, 0);

    // Load while idle, then run.
    l0 = mk(56, 34, 12, 123, 24);
    drive_tod(l0);
    time_load = 1'b1;
    @(negedge clk);
    time_load = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    grab_frame(l0, "load_idle");
    cur = tinc(l0);

    b[0] = mk(59, 59, 23, 365, 23);
    b[1] = mk(59, 59, 23, 365, 24);
    b[2] = mk(59, 59, 23, 366, 24);
    b[3] = mk(59, 59, 23, 365, 99);
    ry   = int'($urandom_range(99, 0));
    b[4] = mk(int'($urandom_range(59, 0)),
              int'($urandom_range(59, 0)),
              int'($urandom_range(23, 0)),
              int'($urandom_range((ry % 4 == 0) ? 366 : 365, 1)),
              ry);

    for (int i = 0; i < 5; i++) begin
      fork
        grab_frame(cur, $sformatf("pre%0d", i));
        begin
          drive_tod(b[i]);
          if (i == 2) begin
            wait_idx(99);
            repeat (BC - 1) @(negedge clk);
          end else begin
            wait_idx(50);
          end
          time_load = 1'b1;
          @(negedge clk);
          time_load = 1'b0;
        end
      join
      grab_frame(b[i], $sformatf("load%0d", i));
      cur = tinc(b[i]);
    end

    // Reset in the middle of a frame.
    wait_idx(30);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_bcode", int'(bcode_out), 0);
    check("rstmid_idx", int'(bit_index), 0);
    check("rstmid_busy", int'(busy), 0);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
